fb_rect_writer: RTL and testbench
=================================

// Module: fb_rect_writer
// PURPOSE
//  Rectangle-fill draw engine feeding one framebuffer write port (addr_wr/data_wr/wr_en) of framebuffer_master.
//  Buffers fill commands (x,y,w,h,colour) in a small FIFO and emits one 4-bit pixel write per clock.
//  Clips each rectangle to the screen and walks it row-major.
//  Frame boundaries come from global_vsync, the VGA vsync, which is active-low.
// PARAMETERS
//  H_RES       640  pixels per line; row stride of the linear address
//  V_RES       480  lines per frame
//  ADDR_W      19   framebuffer address width
//  DATA_W      4    palette index width
//  FIFO_DEPTH  4    command FIFO entries (power of 2, >=2)
//  BG_COLOR    0    clear colour used by FB_CLEAR_EN
// PORTS
//  clock      in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  vsync      in   1       global_vsync, active-low; falling edge = frame boundary
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       FIFO can accept
//  cmd_x      in   10      left column
//  cmd_y      in   9       top row
//  cmd_w      in   10      width in pixels
//  cmd_h      in   9       height in lines
//  cmd_color  in   DATA_W  fill colour
//  wr_addr    out  ADDR_W  framebuffer write address = y*H_RES + x
//  wr_data    out  DATA_W  pixel value
//  wr_en      out  1       write strobe, one pixel per cycle
//  busy       out  1       FIFO non-empty or FSM not IDLE
//  frame_done out  1       1-cycle pulse: FIFO empty and FSM returned to IDLE
// BEHAVIOUR
//  Reset (async, immediate):
//   - FIFO emptied; FSM=IDLE.
//   - wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, cmd_ready=1.
//   - Reset mid-rectangle aborts it; no further writes.
//  Handshake:
//   - Command accepted on an edge where cmd_valid & cmd_ready.
//   - cmd_ready = !full, from registered count only; no combinational path from cmd_valid.
//   - A pop while full frees the slot; cmd_ready rises the next cycle.
//  FSM:
//   - IDLE: FIFO non-empty -> LOAD (pop). CLEAR_PEND set -> CLEAR.
//   - LOAD: clip; compute base = y*H_RES + x with a shift/add, no multiplier.
//     - Zero area -> IDLE.
//     - Otherwise -> FILL.
//   - FILL: wr_en=1 every cycle. addr+1 along the row; at row end addr = row_base + H_RES.
//     - Leaves after exactly w_eff*h_eff writes -> IDLE.
//  Clipping:
//   - x>=H_RES or y>=V_RES -> zero area.
//   - w_eff = min(w, H_RES-x); h_eff = min(h, V_RES-y). Compute with 11-bit intermediates so nothing wraps.
//   - w=0 or h=0 -> zero area: command consumed, no writes.
//  Latency:
//   - First wr_en=1 is in the cycle after the 3rd edge following the accepting edge, when idle.
//   - Back-to-back rectangles are separated by exactly 2 cycles with wr_en=0 (IDLE + LOAD).
//  Outputs are registered. wr_data is held constant for a whole rectangle.
//  frame_done pulses when the FSM goes FILL/LOAD->IDLE with the FIFO empty.
// CONFIGURATION
//  FB_CLEAR_EN defined:
//   - Each vsync falling edge (2-flop synced, edge-detected) sets CLEAR_PEND.
//   - The current rectangle finishes first; CLEAR then writes BG_COLOR to addresses 0..H_RES*V_RES-1, one per cycle.
//   - Queued commands run after CLEAR completes.
//   - An edge during CLEAR is ignored; CLEAR_PEND stays 0.
//  FB_CLEAR_EN undefined: vsync is ignored; CLEAR state and sync flops are absent.
// TESTING
//  - Reset mid-FILL (x=0,y=0,w=640,h=480): wr_en=0 the same cycle; busy=0; cmd_ready=1.
//  - cmd (10,20,3,2,col 5): writes 12810,12811,12812,13450,13451,13452 with data 5; frame_done 1 pulse.
//  - Clip: cmd (638,479,10,10,col 7): exactly 2 writes, addr 307198 and 307199.
//  - Zero/offscreen: w=0, then x=700: no wr_en; both popped; busy falls.
//  - Hold cmd_valid=1 with engine stalled in a long fill: cmd_ready drops after 4 accepts; all 5 rectangles draw in order.
//  - With FB_CLEAR_EN: vsync falls mid-rect: rect completes, then 307200 BG_COLOR writes, then queued cmd.

Source files
------------

// File: rtl/fb_rect_writer_if.sv
// Command and framebuffer-write bundle for fb_rect_writer.
// master = command source / pixel sink, slave = the draw engine.
interface fb_rect_writer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_x;
  logic [8:0]        cmd_y;
  logic [9:0]        cmd_w;
  logic [8:0]        cmd_h;
  logic [DATA_W-1:0] cmd_color;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, wr_addr, wr_data, wr_en
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, wr_addr, wr_data, wr_en
  );
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine: queues (x,y,w,h,colour) commands, clips to screen, writes one pixel per clock.
// Optional FB_CLEAR_EN: a falling vsync edge schedules a full-screen BG_COLOR clear.
module fb_rect_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int BG_COLOR   = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           vsync,
  fb_rect_writer_if.slave bus,
  output logic           busy,
  output logic           frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [9:0]        x;
    logic [8:0]        y;
    logic [9:0]        w;
    logic [8:0]        h;
    logic [DATA_W-1:0] color;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL
`ifdef FB_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t            state;
  cmd_t              mem [FIFO_DEPTH];
  cmd_t              cur;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              push, pop;

  logic [10:0]       w_last, col;
  logic [9:0]        h_last, row;
  logic [ADDR_W-1:0] addr, row_base;

  logic              offscreen, zero_area;
  logic [10:0]       x_room, w_eff;
  logic [9:0]        y_room, h_eff;
  logic [ADDR_W-1:0] base;

`ifdef FB_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);
  logic vs_meta, vs_sync, vs_prev, vs_fall, clear_pend;
  assign vs_fall = vs_prev & ~vs_sync;
  assign pop     = (state == IDLE) && (count != '0) && !clear_pend;
`else
  logic [DATA_W-1:0] unused_cfg;
  assign unused_cfg = DATA_W'(BG_COLOR) ^ {DATA_W{vsync}};
  assign pop        = (state == IDLE) && (count != '0);
`endif

  assign bus.cmd_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_W'(1);
    else if (pop && !push)
      count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= '{x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w, h: bus.cmd_h, color: bus.cmd_color};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // y*H_RES as a sum of shifted copies of y, one per set bit of H_RES.
  function automatic logic [ADDR_W-1:0] row_offset(input logic [8:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int unsigned b = 0; b < 31; b++)
      if (H_RES[b]) acc = acc + (ADDR_W'(y) << b);
    return acc;
  endfunction

  // 11/10-bit clip arithmetic so the room-left and width never wrap.
  always_comb begin
    offscreen = ({1'b0, cur.x} >= 11'(H_RES)) || ({1'b0, cur.y} >= 10'(V_RES));
    x_room    = 11'(H_RES) - {1'b0, cur.x};
    y_room    = 10'(V_RES) - {1'b0, cur.y};
    w_eff     = ({1'b0, cur.w} < x_room) ? {1'b0, cur.w} : x_room;
    h_eff     = ({1'b0, cur.h} < y_room) ? {1'b0, cur.h} : y_room;
    zero_area = offscreen || (w_eff == '0) || (h_eff == '0);
    base      = row_offset(cur.y) + ADDR_W'(cur.x);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      w_last      <= '0;
      h_last      <= '0;
      col         <= '0;
      row         <= '0;
      addr        <= '0;
      row_base    <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
`ifdef FB_CLEAR_EN
      vs_meta     <= 1'b1;
      vs_sync     <= 1'b1;
      vs_prev     <= 1'b1;
      clear_pend  <= 1'b0;
`endif
    end else begin
      bus.wr_en  <= 1'b0;
      frame_done <= 1'b0;
`ifdef FB_CLEAR_EN
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      if (vs_fall && state != CLEAR) clear_pend <= 1'b1;
`endif
      case (state)
        IDLE: begin
`ifdef FB_CLEAR_EN
          if (clear_pend) begin
            clear_pend  <= 1'b0;
            state       <= CLEAR;
            addr        <= '0;
            bus.wr_data <= DATA_W'(BG_COLOR);
            busy        <= 1'b1;
          end else
`endif
          if (count != '0) begin
            cur   <= mem[rd_ptr];
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            busy <= (count_nxt != '0);
          end
        end
        LOAD: begin
          if (zero_area) begin
            state      <= IDLE;
            busy       <= (count_nxt != '0);
            frame_done <= (count_nxt == '0);
          end else begin
            state       <= FILL;
            w_last      <= w_eff - 11'd1;
            h_last      <= h_eff - 10'd1;
            col         <= '0;
            row         <= '0;
            addr        <= base;
            row_base    <= base;
            bus.wr_data <= cur.color;
          end
        end
        FILL: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= addr;
          if (col == w_last) begin
            if (row == h_last) begin
              state      <= IDLE;
              busy       <= (count_nxt != '0);
              frame_done <= (count_nxt == '0);
            end else begin
              row      <= row + 10'd1;
              col      <= '0;
              addr     <= row_base + ADDR_W'(H_RES);
              row_base <= row_base + ADDR_W'(H_RES);
            end
          end else begin
            col  <= col + 11'd1;
            addr <= addr + ADDR_W'(1);
          end
        end
`ifdef FB_CLEAR_EN
        CLEAR: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= addr;
          if (addr == LAST_PIX) begin
            state <= IDLE;
            busy  <= (count_nxt != '0);
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: directed scenarios plus random rectangles
// compared against a plain-arithmetic pixel list model.
module tb_fb_rect_writer;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 4;
  localparam int BG     = 0;

  logic clk = 1'b0;
  logic rst;
  logic vsync;
  logic busy, frame_done;

  always #5 clk = ~clk;

  fb_rect_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_rect_writer #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FIFO_DEPTH(4), .BG_COLOR(BG)
  ) dut (
    .clock(clk), .reset(rst), .vsync(vsync), .bus(bus.slave),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned cyc;
  } wr_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int          fd_count = 0;
  wr_t         obs_q[$];
  int unsigned exp_addr[$];
  int unsigned exp_data[$];
  int unsigned exp_rect[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (bus.wr_en === 1'b1) begin
      w.addr = 32'(bus.wr_addr);
      w.data = 32'(bus.wr_data);
      w.cyc  = cyc;
      obs_q.push_back(w);
    end
    if (frame_done === 1'b1) fd_count++;
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_all();
    obs_q.delete();
    exp_addr.delete();
    exp_data.delete();
    exp_rect.delete();
    fd_count = 0;
  endtask

  // Pixel list of a clipped rectangle, scanned row-major.
  task automatic model_rect(input int unsigned x, y, w, h, c, id);
    int unsigned we, he;
    if (x >= H_RES || y >= V_RES) return;
    we = (w < H_RES - x) ? w : H_RES - x;
    he = (h < V_RES - y) ? h : V_RES - y;
    for (int unsigned r = 0; r < he; r++)
      for (int unsigned k = 0; k < we; k++) begin
        exp_addr.push_back((y + r) * H_RES + x + k);
        exp_data.push_back(c);
        exp_rect.push_back(id);
      end
  endtask

  task automatic send_cmd(input int unsigned x, y, w, h, c, output int unsigned acc, output bit ok);
    @(negedge clk);
    bus.cmd_x     = 10'(x);
    bus.cmd_y     = 9'(y);
    bus.cmd_w     = 10'(w);
    bus.cmd_h     = 9'(h);
    bus.cmd_color = DATA_W'(c);
    bus.cmd_valid = 1'b1;
    ok  = 1'b0;
    acc = 0;
    for (int t = 0; t < 5000; t++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_first_write(input int bound, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (obs_q.size() != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
    n_cmp++; if (bus.wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %0d expected 0", bus.wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int unsigned acc;
    bit ok, idle_ok;
    clear_all();
    model_rect(10, 20, 3, 2, 5, 0);
    send_cmd(10, 20, 3, 2, 5, acc, ok);
    wait_idle(200, idle_ok);
    n_cmp++; if (!(ok && idle_ok)) begin n_fail++; $display("FAIL basic_handshake: accept=%b idle=%b expected 1 1", ok, idle_ok); end
    n_cmp++; if (obs_q.size() != exp_addr.size()) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_addr.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if (obs_q[i].addr !== exp_addr[i] || obs_q[i].data !== exp_data[i]) begin
        n_fail++; $display("FAIL basic_pixel[%0d]: got %0d/%0d expected %0d/%0d", i, obs_q[i].addr, obs_q[i].data, exp_addr[i], exp_data[i]);
      end
    end
    n_cmp++; if (fd_count != 1) begin n_fail++; $display("FAIL basic_frame_done: got %0d pulses expected 1", fd_count); end
    if (obs_q.size() > 0) begin
      n_cmp++; if (obs_q[0].cyc != acc + 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", obs_q[0].cyc - acc, 3); end
    end
  endtask

  task automatic test_clip();
    int unsigned acc;
    bit ok, idle_ok;
    clear_all();
    model_rect(638, 479, 10, 10, 7, 0);
    send_cmd(638, 479, 10, 10, 7, acc, ok);
    wait_idle(200, idle_ok);
    n_cmp++; if (!(ok && idle_ok)) begin n_fail++; $display("FAIL clip_handshake: accept=%b idle=%b expected 1 1", ok, idle_ok); end
    n_cmp++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL clip_count: got %0d expected 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if (obs_q[i].addr !== exp_addr[i] || obs_q[i].data !== exp_data[i]) begin
        n_fail++; $display("FAIL clip_pixel[%0d]: got %0d/%0d expected %0d/%0d", i, obs_q[i].addr, obs_q[i].data, exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_zero();
    int unsigned acc;
    bit ok0, ok1, idle_ok;
    clear_all();
    send_cmd(5, 5, 0, 3, 2, acc, ok0);
    send_cmd(700, 5, 4, 4, 2, acc, ok1);
    wait_idle(200, idle_ok);
    n_cmp++; if (!(ok0 && ok1 && idle_ok)) begin n_fail++; $display("FAIL zero_handshake: accept=%b%b idle=%b expected 1 1", ok0, ok1, idle_ok); end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL zero_writes: got %0d expected 0", obs_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", busy); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b expected 1", bus.cmd_ready); end
  endtask

  task automatic test_back_to_back();
    int unsigned tx[4] = '{5, 100, 630, 0};
    int unsigned ty[4] = '{10, 200, 5, 479};
    int unsigned tw[4] = '{4, 3, 20, 2};
    int unsigned th[4] = '{2, 3, 1, 5};
    int unsigned tc[4] = '{1, 2, 4, 6};
    int unsigned acc;
    int acc_n;
    bit ok, first_ok, idle_ok;
    clear_all();
    model_rect(0, 0, 640, 2, 3, 0);
    for (int k = 0; k < 4; k++) model_rect(tx[k], ty[k], tw[k], th[k], tc[k], k + 1);
    send_cmd(0, 0, 640, 2, 3, acc, ok);
    wait_first_write(50, first_ok);
    acc_n = 0;
    for (int t = 0; t < 200 && acc_n < 4; t++) begin
      @(negedge clk);
      bus.cmd_x     = 10'(tx[acc_n]);
      bus.cmd_y     = 9'(ty[acc_n]);
      bus.cmd_w     = 10'(tw[acc_n]);
      bus.cmd_h     = 9'(th[acc_n]);
      bus.cmd_color = DATA_W'(tc[acc_n]);
      bus.cmd_valid = 1'b1;
      if (bus.cmd_ready === 1'b1) begin
        @(posedge clk);
        acc_n++;
      end
    end
    @(negedge clk);
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b expected 0", bus.cmd_ready); end
    bus.cmd_valid = 1'b0;
    n_cmp++; if (acc_n != 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 4", acc_n); end
    wait_idle(5000, idle_ok);
    n_cmp++; if (!(ok && first_ok && idle_ok)) begin n_fail++; $display("FAIL b2b_progress: accept=%b first=%b idle=%b expected 1 1 1", ok, first_ok, idle_ok); end
    n_cmp++; if (obs_q.size() != exp_addr.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_addr.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if (obs_q[i].addr !== exp_addr[i] || obs_q[i].data !== exp_data[i]) begin
        n_fail++; $display("FAIL b2b_pixel[%0d]: got %0d/%0d expected %0d/%0d", i, obs_q[i].addr, obs_q[i].data, exp_addr[i], exp_data[i]);
      end
      if (i > 0 && exp_rect[i] != exp_rect[i-1]) begin
        n_cmp++;
        if (obs_q[i].cyc - obs_q[i-1].cyc != 3) begin
          n_fail++; $display("FAIL b2b_gap[%0d]: got %0d idle cycles expected 2", exp_rect[i], obs_q[i].cyc - obs_q[i-1].cyc - 1);
        end
      end
    end
  endtask

  task automatic test_random();
    int unsigned x, y, w, h, c, acc;
    bit ok, all_ok, idle_ok;
    clear_all();
    all_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(630, 700) : $urandom_range(0, 620);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(470, 500) : $urandom_range(0, 460);
      w = $urandom_range(0, 12);
      h = $urandom_range(0, 4);
      c = $urandom_range(0, 15);
      model_rect(x, y, w, h, c, k);
      send_cmd(x, y, w, h, c, acc, ok);
      all_ok &= ok;
    end
    wait_idle(5000, idle_ok);
    n_cmp++; if (!(all_ok && idle_ok)) begin n_fail++; $display("FAIL rand_progress: accept=%b idle=%b expected 1 1", all_ok, idle_ok); end
    n_cmp++; if (obs_q.size() != exp_addr.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_addr.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if (obs_q[i].addr !== exp_addr[i] || obs_q[i].data !== exp_data[i]) begin
        n_fail++; $display("FAIL rand_pixel[%0d]: got %0d/%0d expected %0d/%0d", i, obs_q[i].addr, obs_q[i].data, exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned acc;
    int n_before;
    bit ok, first_ok;
    clear_all();
    send_cmd(0, 0, 640, 480, 9, acc, ok);
    wait_first_write(50, first_ok);
    n_cmp++; if (!(ok && first_ok)) begin n_fail++; $display("FAIL rmid_start: accept=%b first=%b expected 1 1", ok, first_ok); end
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_en: got %b expected 0", bus.wr_en); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", bus.cmd_ready); end
    n_before = obs_q.size();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (obs_q.size() != n_before) begin n_fail++; $display("FAIL rmid_no_writes: got %0d expected %0d", obs_q.size(), n_before); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_after: got %b expected 0", busy); end
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int unsigned acc;
    int bad;
    bit ok0, ok1, first_ok, idle_ok;
    clear_all();
    model_rect(0, 0, 640, 1, 3, 0);
    for (int unsigned a = 0; a < H_RES * V_RES; a++) begin
      exp_addr.push_back(a);
      exp_data.push_back(BG);
      exp_rect.push_back(1);
    end
    model_rect(1, 1, 2, 1, 6, 2);
    send_cmd(0, 0, 640, 1, 3, acc, ok0);
    wait_first_write(50, first_ok);
    vsync = 1'b0;
    send_cmd(1, 1, 2, 1, 6, acc, ok1);
    repeat (100) @(negedge clk);
    vsync = 1'b1;
    repeat (1000) @(negedge clk);
    vsync = 1'b0;
    repeat (100) @(negedge clk);
    vsync = 1'b1;
    wait_idle(400000, idle_ok);
    n_cmp++; if (!(ok0 && ok1 && first_ok && idle_ok)) begin n_fail++; $display("FAIL clr_progress: accept=%b%b first=%b idle=%b expected all 1", ok0, ok1, first_ok, idle_ok); end
    n_cmp++; if (obs_q.size() != exp_addr.size()) begin n_fail++; $display("FAIL clr_count: got %0d expected %0d", obs_q.size(), exp_addr.size()); end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_addr.size(); i++)
      if (obs_q[i].addr !== exp_addr[i] || obs_q[i].data !== exp_data[i]) bad++;
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL clr_pixels: got %0d wrong pixels expected 0", bad); end
  endtask
`endif

  initial begin
    rst           = 1'b1;
    vsync         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_w     = '0;
    bus.cmd_h     = '0;
    bus.cmd_color = '0;
    test_reset();
    test_basic();
    test_clip();
    test_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef FB_CLEAR_EN
    test_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
